// File: rtl/a_ctrl_stim_64.sv
// a_ctrl_stim_64: RAM-fed stimulus sequencer with one-vector prefetch; define LOOP_MODE_EN for endless wrap-around passes
module a_ctrl_stim_64 #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
) (
    input  logic              clk_ref,
    input  logic              rst,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              incr_i,
    input  logic [ADDR_W-1:0] nb_stim_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] stimu_o,
    output logic              run_o,
    output logic [ADDR_W-1:0] stim_cnt_o,
    output logic [7:0]        loop_cnt_o,
    output logic              done_o
);
    typedef enum logic [2:0] {IDLE, FILL, RUN, PAUSE, DONE} state_t;
`ifdef LOOP_MODE_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif
    state_t state, state_n;
    logic [ADDR_W-1:0] nb_q, addr_q, cnt_q, lim, addr_n;
    logic [DATA_W-1:0] stimu_q, nxt_q, src;
    logic nxt_v, rd_q, run_q, done_q;
    logic go, take, last, adv, wrap, more, rd;
    always_comb begin
        go      = state == IDLE && start_i;
        take    = state == RUN && incr_i && !stop_i;
        last    = cnt_q == nb_q;
        adv     = take && (LOOP || !last);
        wrap    = take && last && LOOP;
        lim     = go ? nb_stim_i : nb_q;
        more    = LOOP || addr_q < nb_q;
        addr_n  = (LOOP && addr_q == lim - ADDR_W'(1)) ? '0 : addr_q + ADDR_W'(1);
        // a new read is allowed only when its word will have a free slot next cycle
        rd      = (go && nb_stim_i != '0) || (state == FILL && more) ||
                  (state == RUN && !stop_i && more && (take || !(nxt_v || rd_q)));
        src     = rd_q ? mem_data_i : nxt_q;
        state_n = state;
        case (state)
            IDLE:    state_n = go ? (nb_stim_i != '0 ? FILL : DONE) : IDLE;
            FILL:    state_n = RUN;
            RUN:     state_n = stop_i ? PAUSE : (take && last && !LOOP) ? DONE : RUN;
            PAUSE:   state_n = stop_i ? PAUSE : RUN;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state   <= IDLE;
            nb_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            stimu_q <= '0;
            nxt_q   <= '0;
            nxt_v   <= 1'b0;
            rd_q    <= 1'b0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_n;
            rd_q   <= rd;
            run_q  <= state_n == RUN && state != FILL;
            done_q <= state_n == DONE || wrap;
            if (rd)
                addr_q <= addr_n;
            else if (state == DONE)
                addr_q <= '0;
            if (go) begin
                nb_q    <= nb_stim_i;
                cnt_q   <= '0;
                stimu_q <= '0;
            end else if (state == FILL) begin
                stimu_q <= mem_data_i;
                cnt_q   <= ADDR_W'(1);
            end else if (adv) begin
                stimu_q <= src;
                cnt_q   <= last ? ADDR_W'(1) : cnt_q + ADDR_W'(1);
            end
            // park any returning word that was not consumed directly
            if (rd_q && !adv && state != FILL) begin
                nxt_q <= mem_data_i;
                nxt_v <= 1'b1;
            end else if (adv || go) begin
                nxt_v <= 1'b0;
            end
        end
    end
`ifdef LOOP_MODE_EN
    logic [7:0] loop_q;
    always_ff @(posedge clk_ref) begin
        if (rst || go)
            loop_q <= '0;
        else if (wrap && loop_q != 8'hFF)
            loop_q <= loop_q + 8'd1;
    end
    assign loop_cnt_o = loop_q;
`else
    assign loop_cnt_o = '0;
`endif
    assign mem_rd_o   = rd;
    assign mem_addr_o = rd ? addr_q : '0;
    assign stimu_o    = stimu_q;
    assign run_o      = run_q;
    assign stim_cnt_o = cnt_q;
    assign done_o     = done_q;
endmodule
